// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared types and constants for the systolic array sequencer.
package sys_arr_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    FEED,
    FLUSH,
    DONE
  } state_t;

  // Bit offset of C[i][j] in the packed result; C[0][0] sits in the top slice.
  function automatic int c_off(input int i, input int j, input int m);
    return ACC_W * (m * m - 1 - (i * m + j));
  endfunction

endpackage

// File: rtl/sys_arr_skew.sv
// sys_arr_skew: combinational diagonal skew of the A/B buffers for feed step t.
// Lane i of a_vec carries A[i][t-i] and lane j of b_vec carries B[t-j][j];
// lanes whose index falls outside 0..M-1 carry zero padding.
module sys_arr_skew
  import sys_arr_pkg::*;
#(
  parameter int M   = 3,
  parameter int T_W = 3
) (
  input  logic [DATA_W*M-1:0] a_buf [M],
  input  logic [DATA_W*M-1:0] b_buf [M],
  input  logic [T_W-1:0]      t,
  output logic [DATA_W*M-1:0] a_vec,
  output logic [DATA_W*M-1:0] b_vec
);

  // Lane i picks element k of its row/column where i + k equals the step.
  always_comb begin
    a_vec = '0;
    b_vec = '0;
    for (int i = 0; i < M; i++) begin
      for (int k = 0; k < M; k++) begin
        if (int'(t) == i + k) begin
          a_vec[DATA_W*i +: DATA_W] = a_buf[i][DATA_W*k +: DATA_W];
          b_vec[DATA_W*i +: DATA_W] = b_buf[i][DATA_W*k +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/sys_arr_ctrl.sv
// sys_arr_ctrl: load / clear / feed / flush sequencer that owns an MxM systolic
// array. Optional build macro SYS_ARR_CTRL_PERF_EN adds perf_cycles/perf_jobs.
// Handshakes (ld_vld/ld_rdy, res_vld/res_rdy): a beat transfers on a rising CLK
// edge where valid and ready are both high; res_vld and res_c stay stable until
// that edge, and neither side may make ready depend combinationally on valid.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int M      = 3,
  parameter int PE_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 ld_vld,
  output logic                 ld_rdy,
  input  logic [DATA_W*M-1:0]  ld_a_row,
  input  logic [DATA_W*M-1:0]  ld_b_col,
  output logic                 arr_rst,
  output logic                 arr_vld_in,
  output logic                 arr_rdy_out,
  output logic [DATA_W*M-1:0]  arr_a,
  output logic [DATA_W*M-1:0]  arr_b,
  input  logic [ACC_W*M*M-1:0] arr_c,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [ACC_W*M*M-1:0] res_c,
`ifdef SYS_ARR_CTRL_PERF_EN
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_jobs,
`endif
  output state_t               dbg_state
);

  localparam int K_W    = (M > 1) ? $clog2(M) : 1;
  localparam int T_W    = $clog2(3 * M - 1);
  localparam int F_W    = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam int T_LAST = 3 * M - 3;

  state_t                state;
  logic [K_W-1:0]        k_cnt;
  logic [T_W-1:0]        t_cnt;
  logic [F_W-1:0]        f_cnt;
  logic                  clr_q;
  logic [DATA_W*M-1:0]   a_buf [M];
  logic [DATA_W*M-1:0]   b_buf [M];
  logic [T_W-1:0]        t_sel;
  logic [DATA_W*M-1:0]   skew_a;
  logic [DATA_W*M-1:0]   skew_b;

  assign dbg_state = state;
  assign arr_rst   = rst | clr_q;

  // Outputs are registered, so the skew is computed for the step about to be
  // presented: step 0 while leaving CLEAR, step t+1 while in FEED step t.
  assign t_sel = (state == FEED) ? t_cnt + T_W'(1) : '0;

  sys_arr_skew #(
    .M   (M),
    .T_W (T_W)
  ) u_skew (
    .a_buf (a_buf),
    .b_buf (b_buf),
    .t     (t_sel),
    .a_vec (skew_a),
    .b_vec (skew_b)
  );

  // Operand buffers: row k of A and column k of B captured on load beat k.
  always_ff @(posedge CLK) begin
    if (ld_vld && ld_rdy) begin
      a_buf[k_cnt] <= ld_a_row;
      b_buf[k_cnt] <= ld_b_col;
    end
  end

  // Sequencer FSM with all control and array-side outputs registered.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      k_cnt       <= '0;
      t_cnt       <= '0;
      f_cnt       <= '0;
      clr_q       <= 1'b0;
      ld_rdy      <= 1'b0;
      arr_vld_in  <= 1'b0;
      arr_rdy_out <= 1'b0;
      arr_a       <= '0;
      arr_b       <= '0;
      res_vld     <= 1'b0;
      res_c       <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= LOAD;
          ld_rdy <= 1'b1;
          k_cnt  <= '0;
        end
        LOAD: begin
          if (ld_vld) begin
            if (k_cnt == K_W'(M - 1)) begin
              state  <= CLEAR;
              ld_rdy <= 1'b0;
              clr_q  <= 1'b1;
              k_cnt  <= '0;
            end else begin
              k_cnt <= k_cnt + K_W'(1);
            end
          end
        end
        CLEAR: begin
          clr_q       <= 1'b0;
          state       <= FEED;
          t_cnt       <= '0;
          arr_vld_in  <= 1'b1;
          arr_rdy_out <= 1'b1;
          arr_a       <= skew_a;
          arr_b       <= skew_b;
        end
        FEED: begin
          if (t_cnt == T_W'(T_LAST)) begin
            state <= FLUSH;
            f_cnt <= '0;
            arr_a <= '0;
            arr_b <= '0;
          end else begin
            t_cnt <= t_cnt + T_W'(1);
            arr_a <= skew_a;
            arr_b <= skew_b;
          end
        end
        FLUSH: begin
          if (f_cnt == F_W'(PE_LAT - 1)) begin
            state       <= DONE;
            res_c       <= arr_c;
            res_vld     <= 1'b1;
            arr_vld_in  <= 1'b0;
            arr_rdy_out <= 1'b0;
          end else begin
            f_cnt <= f_cnt + F_W'(1);
          end
        end
        DONE: begin
          if (res_rdy) begin
            res_vld <= 1'b0;
            state   <= LOAD;
            ld_rdy  <= 1'b1;
            k_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYS_ARR_CTRL_PERF_EN
  logic [31:0] run_cnt;

  // Job timing: run_cnt restarts on entry to LOAD; its final value plus the
  // current cycle is published when DONE is entered. Jobs count handshakes.
  always_ff @(posedge CLK) begin
    if (rst) begin
      run_cnt     <= '0;
      perf_cycles <= '0;
      perf_jobs   <= '0;
    end else begin
      if (state == IDLE || (state == DONE && res_rdy)) begin
        run_cnt <= '0;
      end else if (state != DONE && run_cnt != '1) begin
        run_cnt <= run_cnt + 32'd1;
      end
      if (state == FLUSH && f_cnt == F_W'(PE_LAT - 1)) begin
        perf_cycles <= (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
      end
      if (res_vld && res_rdy) begin
        perf_jobs <= perf_jobs + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// tb_sys_arr_ctrl: bench for sys_arr_ctrl with a behavioural MxM systolic array
// attached and results compared against a plain matrix product.
module tb_sys_arr_ctrl;
  import sys_arr_pkg::*;

  localparam int M      = 3;
  localparam int PE_LAT = 1;
  localparam int VW     = DATA_W * M;
  localparam int CW     = ACC_W * M * M;
  localparam int LAT    = 3 * M + PE_LAT;

  // ---------------- clock / reset / DUT ----------------
  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          ld_vld = 1'b0;
  logic          ld_rdy;
  logic [VW-1:0] ld_a_row = '0;
  logic [VW-1:0] ld_b_col = '0;
  logic          arr_rst;
  logic          arr_vld_in;
  logic          arr_rdy_out;
  logic [VW-1:0] arr_a;
  logic [VW-1:0] arr_b;
  logic [CW-1:0] arr_c;
  logic          res_vld;
  logic          res_rdy = 1'b0;
  logic [CW-1:0] res_c;
  state_t        dbg_state;
`ifdef SYS_ARR_CTRL_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_jobs;
`endif

  always #5 CLK = ~CLK;

  sys_arr_ctrl #(.M(M), .PE_LAT(PE_LAT)) dut (
    .CLK         (CLK),
    .rst         (rst),
    .ld_vld      (ld_vld),
    .ld_rdy      (ld_rdy),
    .ld_a_row    (ld_a_row),
    .ld_b_col    (ld_b_col),
    .arr_rst     (arr_rst),
    .arr_vld_in  (arr_vld_in),
    .arr_rdy_out (arr_rdy_out),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .arr_c       (arr_c),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .res_c       (res_c),
`ifdef SYS_ARR_CTRL_PERF_EN
    .perf_cycles (perf_cycles),
    .perf_jobs   (perf_jobs),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- behavioural systolic array ----------------
  // Output-stationary: A moves right, B moves down, PE(i,j) accumulates a*b.
  logic [ACC_W-1:0]  acc    [M][M];
  logic [DATA_W-1:0] a_pipe [M][M];
  logic [DATA_W-1:0] b_pipe [M][M];

  function automatic logic [DATA_W-1:0] a_at(input int i, input int j);
    if (j == 0) return arr_a[DATA_W*i +: DATA_W];
    return a_pipe[i][j-1];
  endfunction

  function automatic logic [DATA_W-1:0] b_at(input int i, input int j);
    if (i == 0) return arr_b[DATA_W*j +: DATA_W];
    return b_pipe[i-1][j];
  endfunction

  always @(posedge CLK) begin
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        if (arr_rst) begin
          acc[i][j]    <= '0;
          a_pipe[i][j] <= '0;
          b_pipe[i][j] <= '0;
        end else if (arr_vld_in && arr_rdy_out) begin
          acc[i][j]    <= acc[i][j] + ACC_W'(a_at(i, j)) * ACC_W'(b_at(i, j));
          a_pipe[i][j] <= a_at(i, j);
          b_pipe[i][j] <= b_at(i, j);
        end
      end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        arr_c[c_off(i, j, M) +: ACC_W] = acc[i][j];
  end

  // ---------------- scoreboard / reference ----------------
  int errors = 0;
  int checks = 0;
  logic [CW-1:0]     exp_q [$];
  logic [DATA_W-1:0] ma [M][M];
  logic [DATA_W-1:0] mb [M][M];

  function automatic logic [CW-1:0] model_product();
    logic [CW-1:0]    r;
    logic [ACC_W-1:0] s;
    r = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        s = '0;
        for (int k = 0; k < M; k++) s = s + ACC_W'(ma[i][k]) * ACC_W'(mb[k][j]);
        r[c_off(i, j, M) +: ACC_W] = s;
      end
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] exp_skew_a(input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < M; i++)
      if (t - i >= 0 && t - i < M) v[DATA_W*i +: DATA_W] = ma[i][t-i];
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_skew_b(input int t);
    logic [VW-1:0] v;
    v = '0;
    for (int j = 0; j < M; j++)
      if (t - j >= 0 && t - j < M) v[DATA_W*j +: DATA_W] = mb[t-j][j];
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic rand_mats();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ma[i][j] = DATA_W'($urandom_range(0, 255));
        mb[i][j] = DATA_W'($urandom_range(0, 255));
      end
  endtask

  task automatic fill_mats(input int av, input int bv);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ma[i][j] = DATA_W'(av);
        mb[i][j] = DATA_W'(bv);
      end
  endtask

  task automatic do_reset();
    rst = 1'b1; ld_vld = 1'b0; res_rdy = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst = 1'b0;
  endtask

  // Streams the M beats of ma/mb back to back; returns 1ns after the edge that
  // accepted the last beat and queues the expected product.
  task automatic load_job();
    bit seen;
    for (int k = 0; k < M; k++) begin
      ld_vld = 1'b1;
      for (int i = 0; i < M; i++) begin
        ld_a_row[DATA_W*i +: DATA_W] = ma[k][i];
        ld_b_col[DATA_W*i +: DATA_W] = mb[i][k];
      end
      seen = 1'b0;
      for (int w = 0; w < 50 && !seen; w++) begin
        @(negedge CLK);
        seen = (ld_rdy === 1'b1);
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL load_ready beat %0d: ld_rdy=%b, required 1 within 50 cycles", k, ld_rdy);
      end
      @(posedge CLK); #1;
    end
    ld_vld = 1'b0;
    exp_q.push_back(model_product());
  endtask

  // Follows a job from the last accepted beat to the result handshake. Sample n
  // is the negedge before the n-th edge after acceptance, i.e. n is the edge on
  // which the consumer can first take the result. Load-port noise is driven to
  // confirm beats are ignored outside LOAD.
  task automatic finish_job(input bit chk_skew, input int hold);
    int            lat;
    logic [CW-1:0] held;
    logic [CW-1:0] exp;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      if (n == 1) begin
        checks++;
        if (arr_rst !== 1'b1 || arr_vld_in !== 1'b0 || ld_rdy !== 1'b0) begin
          errors++;
          $display("FAIL clear_pulse: arr_rst=%b arr_vld_in=%b ld_rdy=%b, required 1 0 0",
                   arr_rst, arr_vld_in, ld_rdy);
        end
      end
      if (chk_skew && n >= 2 && n <= 3*M - 1) begin
        checks++;
        if (arr_a !== exp_skew_a(n-2) || arr_b !== exp_skew_b(n-2) ||
            arr_vld_in !== 1'b1 || arr_rdy_out !== 1'b1) begin
          errors++;
          $display("FAIL skew t=%0d: a=%h b=%h en=%b%b, required a=%h b=%h en=11",
                   n-2, arr_a, arr_b, arr_vld_in, arr_rdy_out, exp_skew_a(n-2), exp_skew_b(n-2));
        end
      end
      if (chk_skew && n > 3*M - 1 && n <= 3*M - 1 + PE_LAT) begin
        checks++;
        if (arr_a !== '0 || arr_b !== '0 || arr_vld_in !== 1'b1 || arr_rdy_out !== 1'b1) begin
          errors++;
          $display("FAIL flush: a=%h b=%h en=%b%b, required a=0 b=0 en=11",
                   arr_a, arr_b, arr_vld_in, arr_rdy_out);
        end
      end
      if (res_vld === 1'b1) begin
        lat = n;
        break;
      end
      ld_vld   = 1'($urandom_range(0, 1));
      ld_a_row = VW'($urandom);
      ld_b_col = VW'($urandom);
    end
    ld_vld = 1'b0;
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL latency: res_vld after %0d cycles (0 = never), required %0d", lat, LAT);
    end
    held = res_c;
    for (int h = 0; h < hold; h++) begin
      ld_vld   = 1'($urandom_range(0, 1));
      ld_a_row = VW'($urandom);
      @(negedge CLK);
      checks++;
      if (res_c !== held || res_vld !== 1'b1 || ld_rdy !== 1'b0) begin
        errors++;
        $display("FAIL hold cycle %0d: res_c=%h res_vld=%b ld_rdy=%b, required res_c=%h 1 0",
                 h, res_c, res_vld, ld_rdy, held);
      end
    end
    ld_vld = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    checks++;
    if (res_c !== exp) begin
      errors++;
      $display("FAIL result: res_c=%h, required %h", res_c, exp);
    end
    res_rdy = 1'b1;
    @(posedge CLK); #1;
    res_rdy = 1'b0;
    checks++;
    if (res_vld !== 1'b0 || ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL release: res_vld=%b ld_rdy=%b, required 0 1", res_vld, ld_rdy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; ld_vld = 1'b0; res_rdy = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (dbg_state !== IDLE || ld_rdy !== 1'b0 || res_vld !== 1'b0 || res_c !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: state=%0d ld_rdy=%b res_vld=%b res_c=%h, required IDLE 0 0 0",
               dbg_state, ld_rdy, res_vld, res_c);
    end
    checks++;
    if (arr_rst !== 1'b1 || arr_vld_in !== 1'b0 || arr_rdy_out !== 1'b0 ||
        arr_a !== '0 || arr_b !== '0) begin
      errors++;
      $display("FAIL reset_arr: rst=%b vld=%b rdy=%b a=%h b=%h, required 1 0 0 0 0",
               arr_rst, arr_vld_in, arr_rdy_out, arr_a, arr_b);
    end
    @(posedge CLK); #1 rst = 1'b0;
    @(negedge CLK);
    checks++;
    if (arr_rst !== 1'b0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_release: arr_rst=%b state=%0d, required 0 IDLE", arr_rst, dbg_state);
    end
    @(posedge CLK); #1;
    checks++;
    if (dbg_state !== LOAD || ld_rdy !== 1'b1) begin
      errors++;
      $display("FAIL idle_to_load: state=%0d ld_rdy=%b, required LOAD 1", dbg_state, ld_rdy);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        ma[i][j] = (i == j) ? 8'd1 : 8'd0;
        mb[i][j] = DATA_W'(i * M + j + 1);
      end
    load_job();
    finish_job(1'b1, 0);
  endtask

  task automatic test_skew();
    fill_mats(1, 2);
    load_job();
    finish_job(1'b1, 0);
  endtask

  task automatic test_overflow();
    fill_mats(255, 255);
    load_job();
    finish_job(1'b0, 0);
  endtask

  task automatic test_load_stall();
    logic [4:0]    pat;
    logic [VW-1:0] ra;
    logic [VW-1:0] rb;
    int            beat;
    pat  = 5'b11001;
    beat = 0;
    for (int c = 0; c < 5; c++) begin
      ra = VW'($urandom);
      rb = VW'($urandom);
      ld_vld = pat[c]; ld_a_row = ra; ld_b_col = rb;
      @(negedge CLK);
      checks++;
      if (ld_rdy !== 1'b1) begin
        errors++;
        $display("FAIL stall_ready cycle %0d: ld_rdy=%b, required 1", c, ld_rdy);
      end
      @(posedge CLK); #1;
      if (pat[c] && beat < M) begin
        for (int i = 0; i < M; i++) begin
          ma[beat][i] = ra[DATA_W*i +: DATA_W];
          mb[i][beat] = rb[DATA_W*i +: DATA_W];
        end
        beat++;
      end
    end
    ld_vld = 1'b0;
    exp_q.push_back(model_product());
    finish_job(1'b1, 20);
    rand_mats();
    load_job();
    finish_job(1'b0, 0);
  endtask

  task automatic test_reset_mid_feed();
    rand_mats();
    load_job();
    void'(exp_q.pop_back());
    repeat (5) @(negedge CLK);
    checks++;
    if (dbg_state !== FEED) begin
      errors++;
      $display("FAIL mid_feed_state: state=%0d, required FEED", dbg_state);
    end
    rst = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if (dbg_state !== IDLE || ld_rdy !== 1'b0 || arr_vld_in !== 1'b0 || arr_rdy_out !== 1'b0 ||
        arr_a !== '0 || arr_b !== '0 || res_vld !== 1'b0 || res_c !== '0 || arr_rst !== 1'b1) begin
      errors++;
      $display("FAIL mid_feed_reset: state=%0d ld_rdy=%b en=%b%b a=%h b=%h res_vld=%b arr_rst=%b, required IDLE 0 00 0 0 0 1",
               dbg_state, ld_rdy, arr_vld_in, arr_rdy_out, arr_a, arr_b, res_vld, arr_rst);
    end
    @(posedge CLK); #1 rst = 1'b0;
    rand_mats();
    load_job();
    finish_job(1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 4; j++) begin
      rand_mats();
      load_job();
      finish_job(1'b1, $urandom_range(0, 3));
    end
  endtask

`ifdef SYS_ARR_CTRL_PERF_EN
  task automatic test_perf();
    int exp_cyc;
    exp_cyc = M + 1 + (3*M - 2) + PE_LAT;
    do_reset();
    checks++;
    if (perf_cycles !== 32'd0 || perf_jobs !== 16'd0) begin
      errors++;
      $display("FAIL perf_reset: cycles=%0d jobs=%0d, required 0 0", perf_cycles, perf_jobs);
    end
    for (int j = 0; j < 2; j++) begin
      rand_mats();
      load_job();
      finish_job(1'b0, 0);
    end
    checks++;
    if (perf_jobs !== 16'd2 || perf_cycles !== 32'(exp_cyc)) begin
      errors++;
      $display("FAIL perf_counts: cycles=%0d jobs=%0d, required %0d 2", perf_cycles, perf_jobs, exp_cyc);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_identity();
    test_skew();
    test_overflow();
    test_load_stall();
    test_reset_mid_feed();
    test_back_to_back();
`ifdef SYS_ARR_CTRL_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
